// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = (n > 0) ? n - 1 : 0;
      while (v != 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Digit counter width, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational DIGIT-bit ripple-carry slice; exposes the carry into its MSB for overflow.
module serial_adder_digit #(
   parameter int unsigned DIGIT = 2
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   logic [DIGIT:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int unsigned i = 0; i < DIGIT; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   assign co       = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock, LSB first,
// behind a valid/ready input handshake and in front of a valid/ready output handshake.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned N      = WIDTH / DIGIT;
   localparam int unsigned CW     = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam int unsigned TOP    = WIDTH - DIGIT;

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             in_ready_q;
   logic             out_valid_q;

   logic [DIGIT-1:0] dig_s;
   logic             dig_co;
   logic             dig_cmsb;

   // Operands are shifted right each step, so the active digit always sits at the bottom.
   serial_adder_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .x        (a_q[DIGIT-1:0]),
      .y        (b_q[DIGIT-1:0]),
      .ci       (carry_q),
      .s        (dig_s),
      .co       (dig_co),
      .c_msb_in (dig_cmsb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= sub ? ~b : b;
                  carry_q    <= sub ? 1'b1 : cin;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_ADD;
               end
            end
            ST_ADD: begin
               // Result digits enter at the top and settle into place after N steps.
               sum_q   <= (sum_q >> DIGIT) | (WIDTH'(dig_s) << TOP);
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               carry_q <= dig_co;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  cout_q      <= dig_co;
                  ovf_q       <= dig_co ^ dig_cmsb;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three configurations checked against an arithmetic model.
module tb_serial_adder;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic       ovf;
      logic       cout;
      logic [7:0] sum;
   } exp_t;

   exp_t q8[$];
   exp_t q4[$];
   exp_t qs[$];

   // WIDTH=8, DIGIT=2
   logic       p8_iv = 1'b0, p8_ir, p8_cin = 1'b0, p8_sub = 1'b0;
   logic       p8_ov, p8_or = 1'b1, p8_cout, p8_ovf;
   logic [7:0] p8_a = '0, p8_b = '0, p8_sum;
   // WIDTH=4, DIGIT=1
   logic       p4_iv = 1'b0, p4_ir, p4_cin = 1'b0, p4_sub = 1'b0;
   logic       p4_ov, p4_or = 1'b1, p4_cout, p4_ovf;
   logic [3:0] p4_a = '0, p4_b = '0, p4_sum;
   // WIDTH=8, DIGIT=4
   logic       s8_iv = 1'b0, s8_ir, s8_cin = 1'b0, s8_sub = 1'b0;
   logic       s8_ov, s8_or = 1'b1, s8_cout, s8_ovf;
   logic [7:0] s8_a = '0, s8_b = '0, s8_sum;

   serial_adder #(.WIDTH(8), .DIGIT(2)) dut_p8 (
      .clk(clk), .rst_n(rst_n), .in_valid(p8_iv), .in_ready(p8_ir),
      .a(p8_a), .b(p8_b), .cin(p8_cin), .sub(p8_sub),
      .out_valid(p8_ov), .out_ready(p8_or), .sum(p8_sum), .cout(p8_cout), .overflow(p8_ovf)
   );

   serial_adder #(.WIDTH(4), .DIGIT(1)) dut_p4 (
      .clk(clk), .rst_n(rst_n), .in_valid(p4_iv), .in_ready(p4_ir),
      .a(p4_a), .b(p4_b), .cin(p4_cin), .sub(p4_sub),
      .out_valid(p4_ov), .out_ready(p4_or), .sum(p4_sum), .cout(p4_cout), .overflow(p4_ovf)
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) dut_s8 (
      .clk(clk), .rst_n(rst_n), .in_valid(s8_iv), .in_ready(s8_ir),
      .a(s8_a), .b(s8_b), .cin(s8_cin), .sub(s8_sub),
      .out_valid(s8_ov), .out_ready(s8_or), .sum(s8_sum), .cout(s8_cout), .overflow(s8_ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic summary();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL timeout %s at t=%0t", name, $time);
      summary();
      $finish;
   endtask

   // Reference: integer arithmetic on unsigned and signed interpretations of the operands.
   function automatic exp_t model(input int w, input longint x, input longint y,
                                  input logic c, input logic s);
      longint m, half, sx, sy, r, sr;
      exp_t   e;
      m    = longint'(1) << w;
      half = m / 2;
      sx   = (x >= half) ? x - m : x;
      sy   = (y >= half) ? y - m : y;
      if (s) begin
         r      = x - y;
         sr     = sx - sy;
         e.cout = (x >= y);
      end else begin
         r      = x + y + longint'(c);
         sr     = sx + sy + longint'(c);
         e.cout = (r >= m);
      end
      e.sum = 8'(((r % m) + m) % m);
      e.ovf = (sr < -half) || (sr >= half);
      return e;
   endfunction

   // Monitors: a result is consumed on the edge after a negedge that sees out_valid && out_ready.
   always @(negedge clk) begin : mon_p8
      exp_t e;
      if (rst_n && p8_ov && p8_or) begin
         check("p8_result_expected", 32'(q8.size() != 0), 32'd1);
         if (q8.size() != 0) begin
            e = q8.pop_front();
            check("p8_sum", 32'(p8_sum), 32'(e.sum));
            check("p8_cout", 32'(p8_cout), 32'(e.cout));
            check("p8_ovf", 32'(p8_ovf), 32'(e.ovf));
         end
      end
   end

   always @(negedge clk) begin : mon_p4
      exp_t e;
      if (rst_n && p4_ov && p4_or) begin
         check("p4_result_expected", 32'(q4.size() != 0), 32'd1);
         if (q4.size() != 0) begin
            e = q4.pop_front();
            check("p4_sum", 32'(p4_sum), 32'(e.sum));
            check("p4_cout", 32'(p4_cout), 32'(e.cout));
            check("p4_ovf", 32'(p4_ovf), 32'(e.ovf));
         end
      end
   end

   always @(negedge clk) begin : mon_s8
      exp_t e;
      if (rst_n && s8_ov && s8_or) begin
         check("s8_result_expected", 32'(qs.size() != 0), 32'd1);
         if (qs.size() != 0) begin
            e = qs.pop_front();
            check("s8_sum", 32'(s8_sum), 32'(e.sum));
            check("s8_cout", 32'(s8_cout), 32'(e.cout));
            check("s8_ovf", 32'(s8_ovf), 32'(e.ovf));
         end
      end
   end

   // Returns at a negedge where the selected DUT shows in_ready (accept on the next posedge).
   task automatic wait_accept(input int which);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         case (which)
            0:       ok = p8_ir;
            1:       ok = p4_ir;
            default: ok = s8_ir;
         endcase
      end
      if (!ok) timeout("wait_accept");
   endtask

   // Waits until the selected scoreboard is empty and the DUT is back in IDLE.
   task automatic drain(input int which);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(posedge clk);
         #1;
         case (which)
            0:       ok = (q8.size() == 0) && p8_ir;
            1:       ok = (q4.size() == 0) && p4_ir;
            default: ok = (qs.size() == 0) && s8_ir;
         endcase
      end
      if (!ok) timeout("drain");
   endtask

   // One WIDTH=8/DIGIT=2 operation; returns just after the edge that raises out_valid.
   task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
      int lat;
      p8_a   = x;
      p8_b   = y;
      p8_cin = c;
      p8_sub = s;
      p8_iv  = 1'b1;
      wait_accept(0);
      q8.push_back(model(8, longint'(x), longint'(y), c, s));
      @(posedge clk);
      #1;
      p8_iv  = 1'b0;
      p8_a   = ~x;
      p8_b   = 8'($urandom);
      p8_cin = ~c;
      p8_sub = ~s;
      lat    = 0;
      for (int i = 0; i < 20 && !p8_ov; i++) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("p8_latency", 32'(lat), 32'd4);
   endtask

   initial begin : main
      exp_t held;
      int   prev_acc;

      repeat (2) @(posedge clk);
      #1;
      check("rst_p8_in_ready", 32'(p8_ir), 32'd1);
      check("rst_p8_out_valid", 32'(p8_ov), 32'd0);
      check("rst_p8_sum", 32'(p8_sum), 32'd0);
      check("rst_p8_cout", 32'(p8_cout), 32'd0);
      check("rst_p8_ovf", 32'(p8_ovf), 32'd0);
      check("rst_p4_in_ready", 32'(p4_ir), 32'd1);
      check("rst_p4_out_valid", 32'(p4_ov), 32'd0);
      check("rst_s8_in_ready", 32'(s8_ir), 32'd1);
      check("rst_s8_out_valid", 32'(s8_ov), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed boundary cases, then random traffic.
      send8(8'hFF, 8'h01, 1'b0, 1'b0);
      send8(8'h7F, 8'h01, 1'b0, 1'b0);
      send8(8'h05, 8'h07, 1'b0, 1'b1);
      send8(8'h80, 8'h01, 1'b0, 1'b1);
      send8(8'h10, 8'h20, 1'b1, 1'b1);
      send8(8'hFF, 8'hFF, 1'b1, 1'b0);
      for (int i = 0; i < 30; i++)
         send8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      drain(0);

      // Backpressure: result must hold while out_ready is low.
      p8_or = 1'b0;
      send8(8'hC3, 8'h5A, 1'b1, 1'b0);
      held   = model(8, 64'hC3, 64'h5A, 1'b1, 1'b0);
      p8_a   = 8'h21;
      p8_b   = 8'h43;
      p8_cin = 1'b0;
      p8_sub = 1'b1;
      p8_iv  = 1'b1;
      q8.push_back(model(8, 64'h21, 64'h43, 1'b0, 1'b1));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", 32'(p8_ov), 32'd1);
         check("bp_in_ready", 32'(p8_ir), 32'd0);
         check("bp_sum", 32'(p8_sum), 32'(held.sum));
         check("bp_cout", 32'(p8_cout), 32'(held.cout));
         check("bp_ovf", 32'(p8_ovf), 32'(held.ovf));
      end
      @(posedge clk);
      #1;
      p8_or = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_out_valid", 32'(p8_ov), 32'd0);
      check("bp_release_in_ready", 32'(p8_ir), 32'd1);
      wait_accept(0);
      @(posedge clk);
      #1;
      p8_iv = 1'b0;
      drain(0);

      // Reset two cycles into ADD discards the operation in flight.
      p8_a  = 8'hAB;
      p8_b  = 8'h5F;
      p8_iv = 1'b1;
      wait_accept(0);
      @(posedge clk);
      #1;
      p8_iv = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 32'(p8_ir), 32'd1);
      check("mid_rst_out_valid", 32'(p8_ov), 32'd0);
      check("mid_rst_sum", 32'(p8_sum), 32'd0);
      check("mid_rst_cout", 32'(p8_cout), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send8(8'h12, 8'h34, 1'b0, 1'b0);
      drain(0);

      // Exhaustive WIDTH=4, DIGIT=1 with in_valid held high.
      p4_iv = 1'b1;
      for (int ia = 0; ia < 16; ia++)
         for (int ib = 0; ib < 16; ib++)
            for (int ic = 0; ic < 2; ic++)
               for (int is = 0; is < 2; is++) begin
                  p4_a   = 4'(ia);
                  p4_b   = 4'(ib);
                  p4_cin = 1'(ic);
                  p4_sub = 1'(is);
                  wait_accept(1);
                  q4.push_back(model(4, longint'(ia), longint'(ib), 1'(ic), 1'(is)));
                  @(posedge clk);
                  #1;
               end
      p4_iv = 1'b0;
      drain(1);

      // Streaming WIDTH=8, DIGIT=4: accepts every N+2 = 4 cycles.
      s8_iv    = 1'b1;
      prev_acc = 0;
      for (int i = 0; i < 16; i++) begin
         s8_a   = 8'($urandom);
         s8_b   = 8'($urandom);
         s8_cin = 1'($urandom);
         s8_sub = 1'($urandom);
         wait_accept(2);
         qs.push_back(model(8, longint'(s8_a), longint'(s8_b), s8_cin, s8_sub));
         if (i > 0) check("s8_interval", 32'(cyc - prev_acc), 32'd4);
         prev_acc = cyc;
         @(posedge clk);
         #1;
      end
      s8_iv = 1'b0;
      drain(2);

      check("q8_empty", 32'(q8.size()), 32'd0);
      check("q4_empty", 32'(q4.size()), 32'd0);
      check("qs_empty", 32'(qs.size()), 32'd0);
      summary();
      $finish;
   end

endmodule
